// File: rtl/cr_clic_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_pkg
// Description : Shared types and constants for the CLIC interrupt scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef CLIC_INTNUM
`define CLIC_INTNUM 80
`endif

package cr_clic_pkg;

    // Number of interrupt sources in the default CLIC build
    localparam int c_intnum_default = `CLIC_INTNUM;

    // Entries evaluated per scan cycle by default
    localparam int c_grp_default = 8;

    // Width of one clicintctl field
    localparam int c_ctlw = 8;

    // Scanner state encoding
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        HOLD = 2'b10
    } scan_state_e;

    // Number of scan cycles needed to cover all sources once
    function automatic int f_npass(input int intnum, input int grp);
        return (intnum + grp - 1) / grp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cr_clic_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_scan_if
// Description : Registered interrupt request / acknowledge handshake between
//               the CLIC scanner (master) and the core (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cr_clic_scan_if #(
    parameter int IDW  = 7,
    parameter int CTLW = 8
);
    logic            scan_core_int_vld;
    logic [IDW-1:0]  scan_core_int_id;
    logic [CTLW-1:0] scan_core_int_lvl;
    logic            core_scan_int_ack;

    modport master (
        output scan_core_int_vld,
        output scan_core_int_id,
        output scan_core_int_lvl,
        input  core_scan_int_ack
    );

    modport slave (
        input  scan_core_int_vld,
        input  scan_core_int_id,
        input  scan_core_int_lvl,
        output core_scan_int_ack
    );
endinterface
`default_nettype wire

// File: rtl/cr_clic_scan_grp.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_scan_grp
// Description : Combinational GRP-wide maximum finder. Picks the candidate
//               (ip & ie) with the highest CTL; ties go to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module cr_clic_scan_grp
    import cr_clic_pkg::*;
#(
    parameter int GRP  = c_grp_default,
    parameter int CTLW = c_ctlw,
    parameter int IDW  = 7
) (
    input  logic [GRP-1:0]      ip,
    input  logic [GRP-1:0]      ie,
    input  logic [GRP*CTLW-1:0] ctl,
    input  logic [IDW-1:0]      base,
    output logic                grp_vld,
    output logic [IDW-1:0]      grp_id,
    output logic [CTLW-1:0]     grp_lvl
);

    // Leaves are padded to a power of two so the tree is a full binary heap
    localparam int c_leaves = 1 << $clog2(GRP);

    logic [c_leaves-1:0]      w_cand_pad;
    logic [c_leaves*CTLW-1:0] w_ctl_pad;

    logic            w_nv  [2*c_leaves];
    logic [IDW-1:0]  w_nid [2*c_leaves];
    logic [CTLW-1:0] w_nl  [2*c_leaves];

    assign w_cand_pad = (c_leaves)'(ip & ie);
    assign w_ctl_pad  = (c_leaves*CTLW)'(ctl);

    // Heap-indexed comparator tree; the left child always holds lower indices,
    // so the right child only wins on a strictly greater level
    always_comb begin
        for (int n = 0; n < 2 * c_leaves; n++) begin
            w_nv[n]  = 1'b0;
            w_nid[n] = '0;
            w_nl[n]  = '0;
        end
        for (int k = 0; k < c_leaves; k++) begin
            w_nv[c_leaves + k]  = w_cand_pad[k];
            w_nid[c_leaves + k] = base + IDW'(k);
            w_nl[c_leaves + k]  = w_ctl_pad[k*CTLW +: CTLW];
        end
        for (int n = c_leaves - 1; n >= 1; n--) begin
            if (w_nv[2*n+1] && (!w_nv[2*n] || (w_nl[2*n+1] > w_nl[2*n]))) begin
                w_nv[n]  = 1'b1;
                w_nid[n] = w_nid[2*n+1];
                w_nl[n]  = w_nl[2*n+1];
            end else begin
                w_nv[n]  = w_nv[2*n];
                w_nid[n] = w_nid[2*n];
                w_nl[n]  = w_nl[2*n];
            end
        end
        grp_vld = w_nv[1];
        grp_id  = w_nid[1];
        grp_lvl = w_nl[1];
    end

endmodule
`default_nettype wire

// File: rtl/cr_clic_scan.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_scan
// Description : Sequential CLIC interrupt-selection scheduler. Scans GRP kid
//               entries per cycle, keeps a running best, filters it against
//               mintthresh at end of pass and presents it to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module cr_clic_scan
    import cr_clic_pkg::*;
#(
    parameter int INTNUM = c_intnum_default,
    parameter int GRP    = c_grp_default,
    parameter int CTLW   = c_ctlw,
    parameter int IDW    = $clog2(INTNUM)
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic [INTNUM-1:0]      kid_scan_ip_vec,
    input  logic [INTNUM-1:0]      kid_scan_ie_vec,
    input  logic [INTNUM*CTLW-1:0] kid_scan_ctl_vec,
    input  logic [CTLW-1:0]        ctrl_scan_mintthresh,
    input  logic                   busif_xx_write_vld,
    cr_clic_scan_if.master         core_if,
    output logic                   scan_busy
);

    localparam int c_npass    = f_npass(INTNUM, GRP);
    localparam int c_last_ptr = (c_npass - 1) * GRP;

    scan_state_e     r_state, w_state_nxt;
    logic [IDW-1:0]  r_ptr, w_ptr_nxt;
    logic            r_best_vld, w_best_vld_nxt;
    logic [IDW-1:0]  r_best_id, w_best_id_nxt;
    logic [CTLW-1:0] r_best_lvl, w_best_lvl_nxt;
    logic            r_int_vld, w_int_vld_nxt;
    logic [IDW-1:0]  r_int_id, w_int_id_nxt;
    logic [CTLW-1:0] r_int_lvl, w_int_lvl_nxt;
    logic            r_busy;

    logic [GRP-1:0]      w_grp_ip;
    logic [GRP-1:0]      w_grp_ie;
    logic [GRP*CTLW-1:0] w_grp_ctl;
    logic                w_grp_vld;
    logic [IDW-1:0]      w_grp_id;
    logic [CTLW-1:0]     w_grp_lvl;
    logic                w_mrg_vld;
    logic [IDW-1:0]      w_mrg_id;
    logic [CTLW-1:0]     w_mrg_lvl;
    logic                w_hold_pend;
    logic                w_last_grp;

    // Shifting the vectors down by ptr zero-fills indices past INTNUM, which
    // masks out the tail of the final group for free
    assign w_grp_ip  = GRP'(kid_scan_ip_vec >> r_ptr);
    assign w_grp_ie  = GRP'(kid_scan_ie_vec >> r_ptr);
    assign w_grp_ctl = (GRP*CTLW)'(kid_scan_ctl_vec >> (r_ptr * CTLW));

    // The presented entry must still be pending and enabled to stay in HOLD
    assign w_hold_pend = 1'((kid_scan_ip_vec & kid_scan_ie_vec) >> r_int_id);

    assign w_last_grp = (r_ptr == IDW'(c_last_ptr));

    cr_clic_scan_grp #(
        .GRP  (GRP),
        .CTLW (CTLW),
        .IDW  (IDW)
    ) u_grp (
        .ip      (w_grp_ip),
        .ie      (w_grp_ie),
        .ctl     (w_grp_ctl),
        .base    (r_ptr),
        .grp_vld (w_grp_vld),
        .grp_id  (w_grp_id),
        .grp_lvl (w_grp_lvl)
    );

    // State register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pointer, running-best and output-register update logic
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_best_vld_nxt = r_best_vld;
        w_best_id_nxt  = r_best_id;
        w_best_lvl_nxt = r_best_lvl;
        w_int_vld_nxt  = r_int_vld;
        w_int_id_nxt   = r_int_id;
        w_int_lvl_nxt  = r_int_lvl;

        // Group winner only displaces the best on a strictly higher level,
        // so equal levels resolve to the earlier (lower) ID across the pass
        w_mrg_vld = r_best_vld;
        w_mrg_id  = r_best_id;
        w_mrg_lvl = r_best_lvl;
        if (w_grp_vld && (!r_best_vld || (w_grp_lvl > r_best_lvl))) begin
            w_mrg_vld = 1'b1;
            w_mrg_id  = w_grp_id;
            w_mrg_lvl = w_grp_lvl;
        end

        unique case (r_state)
            IDLE: begin
                w_state_nxt    = SCAN;
                w_ptr_nxt      = '0;
                w_best_vld_nxt = 1'b0;
                w_best_id_nxt  = '0;
                w_best_lvl_nxt = '0;
            end
            SCAN: begin
                if (busif_xx_write_vld || w_last_grp) begin
                    w_ptr_nxt      = '0;
                    w_best_vld_nxt = 1'b0;
                    w_best_id_nxt  = '0;
                    w_best_lvl_nxt = '0;
                    if (!busif_xx_write_vld && w_mrg_vld &&
                        (w_mrg_lvl > ctrl_scan_mintthresh)) begin
                        w_state_nxt   = HOLD;
                        w_int_vld_nxt = 1'b1;
                        w_int_id_nxt  = w_mrg_id;
                        w_int_lvl_nxt = w_mrg_lvl;
                    end
                end else begin
                    w_ptr_nxt      = r_ptr + IDW'(GRP);
                    w_best_vld_nxt = w_mrg_vld;
                    w_best_id_nxt  = w_mrg_id;
                    w_best_lvl_nxt = w_mrg_lvl;
                end
            end
            HOLD: begin
                if (core_if.core_scan_int_ack || busif_xx_write_vld || !w_hold_pend) begin
                    w_state_nxt    = SCAN;
                    w_int_vld_nxt  = 1'b0;
                    w_ptr_nxt      = '0;
                    w_best_vld_nxt = 1'b0;
                    w_best_id_nxt  = '0;
                    w_best_lvl_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: pointer, running best, presented interrupt, busy flag
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ptr      <= '0;
            r_best_vld <= 1'b0;
            r_best_id  <= '0;
            r_best_lvl <= '0;
            r_int_vld  <= 1'b0;
            r_int_id   <= '0;
            r_int_lvl  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_best_vld <= w_best_vld_nxt;
            r_best_id  <= w_best_id_nxt;
            r_best_lvl <= w_best_lvl_nxt;
            r_int_vld  <= w_int_vld_nxt;
            r_int_id   <= w_int_id_nxt;
            r_int_lvl  <= w_int_lvl_nxt;
            r_busy     <= (w_state_nxt == SCAN);
        end
    end

    assign core_if.scan_core_int_vld = r_int_vld;
    assign core_if.scan_core_int_id  = r_int_id;
    assign core_if.scan_core_int_lvl = r_int_lvl;
    assign scan_busy                 = r_busy;

endmodule
`default_nettype wire
